// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key-schedule engine: FSM state type,
// GF(2^8) doubling, key-length check and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StOutput = 2'd2
  } aes_ks_state_e;

  localparam logic [7:0] AES_RCON_POLY = 8'h1b;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] AES_SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return AES_SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

  function automatic bit nk_is_legal(input int unsigned nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-boxes over a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [0:31] word_i,
  output logic [0:31] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign word_o[8*b +: 8] = aes_sbox(word_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES key expansion (one word per clock) followed by round keys streamed from
// round NR down to round 0 for the inverse cipher.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = NK + 6,
  parameter int unsigned NW = 4 * (NR + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:255] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [0:127] rk_out,
  output logic [0:3]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy
);

  if (!nk_is_legal(NK) || (NR != NK + 6) || (NW != 4 * (NR + 1))) begin : g_bad_params
    $error("aes_inv_key_sched: NK must be 4, 6 or 8 and NR/NW must not be overridden");
  end

  // Every legal NW (44..60) needs exactly a 6-bit word index.
  localparam int unsigned IdxW = 6;
  localparam logic [IdxW-1:0] NkIdx = IdxW'(NK);
  localparam logic [IdxW-1:0] NwIdx = IdxW'(NW);
  localparam logic [3:0]      NrIdx = 4'(NR);

  aes_ks_state_e   state_q, state_d;
  logic [IdxW-1:0] i_q, i_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [3:0]      r_q, r_d;
  logic [31:0]     w_q [NW];

  logic            load, we;
  logic [IdxW-1:0] phase;
  logic            rot_step, sub_step;
  logic [31:0]     prev_word, back_word, sub_in, sub_out, temp, new_word;
  logic [IdxW-1:0] base;

  // Bits beyond 32*NK are intentionally ignored for shorter keys.
  logic unused_key_bits;
  assign unused_key_bits = ^key_in;

  // Next word of the expansion: w[i] = w[i-NK] ^ f(w[i-1]).
  always_comb begin
    phase     = IdxW'(32'(i_q) % NK);
    rot_step  = (phase == '0);
    sub_step  = (NK == 8) && (phase == IdxW'(4));
    prev_word = w_q[i_q - IdxW'(1)];
    back_word = w_q[i_q - NkIdx];
    sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (rot_step) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (sub_step) begin
      temp = sub_out;
    end else begin
      temp = prev_word;
    end
    new_word = back_word ^ temp;
  end

  // Single S-box bank shared by the RotWord and NK=8 mid-key cases.
  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // FSM next-state and counter updates.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rcon_d  = rcon_q;
    r_d     = r_q;
    load    = 1'b0;
    we      = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          load    = 1'b1;
          i_d     = NkIdx;
          rcon_d  = 8'h01;
          state_d = StExpand;
        end
      end
      StExpand: begin
        // One idle cycle after the final write before keys are presented.
        if (i_q == NwIdx) begin
          r_d     = NrIdx;
          state_d = StOutput;
        end else begin
          we  = 1'b1;
          i_d = i_q + IdxW'(1);
          if (rot_step) begin
            rcon_d = xtime(rcon_q);
          end
        end
      end
      StOutput: begin
        if (rk_ready) begin
          if (r_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            r_d = r_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      rcon_q  <= 8'h01;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rcon_q  <= rcon_d;
      r_q     <= r_d;
    end
  end

  // Round-key buffer; contents are don't-care after reset, so it has none.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < int'(NK); k++) begin
        w_q[IdxW'(k)] <= key_in[32*k +: 32];
      end
    end else if (we) begin
      w_q[i_q] <= new_word;
    end
  end

  // Outputs decoded from state; the key bus is forced to zero outside OUTPUT.
  always_comb begin
    base      = {r_q, 2'b00};
    key_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rk_valid  = (state_q == StOutput);
    rk_last   = rk_valid && (r_q == 4'd0);
    rk_idx    = rk_valid ? r_q : 4'd0;
    rk_out    = '0;
    if (rk_valid) begin
      rk_out = {w_q[base], w_q[base + IdxW'(1)], w_q[base + IdxW'(2)], w_q[base + IdxW'(3)]};
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 key-expansion vectors.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:255] key;
  logic         key_valid;
  logic         rk_ready;
  int           sel;

  logic         kr4, kr6, kr8, rv4, rv6, rv8, rl4, rl6, rl8, bz4, bz6, bz8;
  logic [0:127] ro4, ro6, ro8;
  logic [0:3]   ri4, ri6, ri8;
  logic         cur_key_ready, cur_rk_valid, cur_rk_last, cur_busy;
  logic [0:127] cur_rk_out;
  logic [0:3]   cur_rk_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_inv_key_sched #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_in(key), .key_valid(key_valid && sel == 4),
    .key_ready(kr4), .rk_out(ro4), .rk_idx(ri4), .rk_valid(rv4), .rk_ready(rk_ready),
    .rk_last(rl4), .busy(bz4)
  );
  aes_inv_key_sched #(.NK(6)) u_dut6 (
    .clk(clk), .rst(rst), .key_in(key), .key_valid(key_valid && sel == 6),
    .key_ready(kr6), .rk_out(ro6), .rk_idx(ri6), .rk_valid(rv6), .rk_ready(rk_ready),
    .rk_last(rl6), .busy(bz6)
  );
  aes_inv_key_sched #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst), .key_in(key), .key_valid(key_valid && sel == 8),
    .key_ready(kr8), .rk_out(ro8), .rk_idx(ri8), .rk_valid(rv8), .rk_ready(rk_ready),
    .rk_last(rl8), .busy(bz8)
  );

  always_comb begin
    cur_key_ready = kr4; cur_rk_valid = rv4; cur_rk_last = rl4; cur_busy = bz4;
    cur_rk_out = ro4; cur_rk_idx = ri4;
    if (sel == 6) begin
      cur_key_ready = kr6; cur_rk_valid = rv6; cur_rk_last = rl6; cur_busy = bz6;
      cur_rk_out = ro6; cur_rk_idx = ri6;
    end else if (sel == 8) begin
      cur_key_ready = kr8; cur_rk_valid = rv8; cur_rk_last = rl8; cur_busy = bz8;
      cur_rk_out = ro8; cur_rk_idx = ri8;
    end
  end

  // FIPS-197 A.1 round keys, index = round.
  logic [0:127] exp128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [0:255] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] KeyAlt = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  // Presents a key for one edge, leaving the bench 1 time unit after that edge.
  task automatic accept_key(input logic [0:255] k);
    key = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  // Advances until rk_valid, counting cycles and busy samples; bounded.
  task automatic wait_valid(output int cycles, output int nbusy, output bit timeout);
    cycles = 0; nbusy = 0; timeout = 1'b0;
    while (!cur_rk_valid) begin
      if (cycles >= 300) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cycles++;
      if (cur_busy) nbusy++;
    end
  endtask

  task automatic test_reset();
    sel = 4;
    n_checks++; if (cur_key_ready !== 1'b1) begin n_errors++;
      $display("FAIL reset_key_ready: got %b expected 1", cur_key_ready); end
    n_checks++; if (cur_busy !== 1'b0) begin n_errors++;
      $display("FAIL reset_busy: got %b expected 0", cur_busy); end
    n_checks++; if (cur_rk_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_rk_valid: got %b expected 0", cur_rk_valid); end
    n_checks++; if (cur_rk_last !== 1'b0) begin n_errors++;
      $display("FAIL reset_rk_last: got %b expected 0", cur_rk_last); end
    n_checks++; if (cur_rk_out !== 128'h0) begin n_errors++;
      $display("FAIL reset_rk_out: got %h expected 0", cur_rk_out); end
    n_checks++; if (cur_rk_idx !== 4'd0) begin n_errors++;
      $display("FAIL reset_rk_idx: got %0d expected 0", cur_rk_idx); end
  endtask

  task automatic test_aes128();
    int cycles, nbusy, total_busy;
    bit to;
    sel = 4; rk_ready = 1'b1;
    accept_key(Key128);
    total_busy = cur_busy ? 1 : 0;
    n_checks++; if (cur_key_ready !== 1'b0) begin n_errors++;
      $display("FAIL aes128_key_ready_busy: got %b expected 0", cur_key_ready); end
    wait_valid(cycles, nbusy, to);
    total_busy += nbusy;
    n_checks++; if (to) begin n_errors++;
      $display("FAIL aes128_timeout: got timeout expected rk_valid"); return; end
    n_checks++; if (cycles != 41) begin n_errors++;
      $display("FAIL aes128_latency: got %0d expected 41", cycles); end
    for (int b = 0; b < 11; b++) begin
      n_checks++; if (cur_rk_valid !== 1'b1) begin n_errors++;
        $display("FAIL aes128_valid[%0d]: got %b expected 1", b, cur_rk_valid); end
      n_checks++; if (cur_rk_idx !== 4'(10 - b)) begin n_errors++;
        $display("FAIL aes128_idx[%0d]: got %0d expected %0d", b, cur_rk_idx, 10 - b); end
      n_checks++; if (cur_rk_out !== exp128[10 - b]) begin n_errors++;
        $display("FAIL aes128_rk[%0d]: got %h expected %h", b, cur_rk_out, exp128[10 - b]); end
      n_checks++; if (cur_rk_last !== (b == 10)) begin n_errors++;
        $display("FAIL aes128_last[%0d]: got %b expected %b", b, cur_rk_last, b == 10); end
      @(posedge clk); #1;
      if (cur_busy) total_busy++;
    end
    n_checks++; if (total_busy != 52) begin n_errors++;
      $display("FAIL aes128_occupancy: got %0d expected 52", total_busy); end
    n_checks++; if (cur_key_ready !== 1'b1 || cur_rk_valid !== 1'b0 || cur_busy !== 1'b0) begin
      n_errors++; $display("FAIL aes128_end: got ready/valid/busy %b%b%b expected 100",
        cur_key_ready, cur_rk_valid, cur_busy); end
    n_checks++; if (cur_rk_out !== 128'h0) begin n_errors++;
      $display("FAIL aes128_bus_idle: got %h expected 0", cur_rk_out); end
  endtask

  task automatic test_aes_wide(input int nk, input logic [0:255] k, input int nr,
                               input int exp_cycles, input logic [0:127] first_rk,
                               input logic [0:127] rk1, input logic [0:127] rk0);
    int cycles, nbusy;
    bit to;
    sel = nk; rk_ready = 1'b1;
    accept_key(k);
    wait_valid(cycles, nbusy, to);
    n_checks++; if (to) begin n_errors++;
      $display("FAIL aes%0d_timeout: got timeout expected rk_valid", nk); return; end
    n_checks++; if (cycles != exp_cycles) begin n_errors++;
      $display("FAIL aes%0d_latency: got %0d expected %0d", nk, cycles, exp_cycles); end
    for (int b = 0; b <= nr; b++) begin
      n_checks++; if (cur_rk_idx !== 4'(nr - b) || cur_rk_valid !== 1'b1) begin n_errors++;
        $display("FAIL aes%0d_idx[%0d]: got %0d/%b expected %0d/1", nk, b, cur_rk_idx,
          cur_rk_valid, nr - b); end
      n_checks++; if (cur_rk_last !== (b == nr)) begin n_errors++;
        $display("FAIL aes%0d_last[%0d]: got %b expected %b", nk, b, cur_rk_last, b == nr); end
      if (b == 0) begin
        n_checks++; if (cur_rk_out !== first_rk) begin n_errors++;
          $display("FAIL aes%0d_first: got %h expected %h", nk, cur_rk_out, first_rk); end
      end
      if (b == nr - 1) begin
        n_checks++; if (cur_rk_out !== rk1) begin n_errors++;
          $display("FAIL aes%0d_round1: got %h expected %h", nk, cur_rk_out, rk1); end
      end
      if (b == nr) begin
        n_checks++; if (cur_rk_out !== rk0) begin n_errors++;
          $display("FAIL aes%0d_round0: got %h expected %h", nk, cur_rk_out, rk0); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (cur_busy !== 1'b0 || cur_key_ready !== 1'b1) begin n_errors++;
      $display("FAIL aes%0d_end: got busy/ready %b%b expected 01", nk, cur_busy,
        cur_key_ready); end
  endtask

  task automatic test_backpressure();
    int cycles, nbusy, exp_idx, beats, guard;
    bit to, stalled, go;
    logic [0:127] held;
    sel = 4; rk_ready = 1'b0;
    accept_key(Key128);
    wait_valid(cycles, nbusy, to);
    n_checks++; if (to) begin n_errors++;
      $display("FAIL bp_timeout: got timeout expected rk_valid"); return; end
    exp_idx = 10; beats = 0; guard = 0; stalled = 1'b0; held = '0;
    while (beats < 11 && guard < 400) begin
      guard++;
      n_checks++; if (cur_rk_valid !== 1'b1 || cur_rk_idx !== 4'(exp_idx)) begin n_errors++;
        $display("FAIL bp_idx: got %b/%0d expected 1/%0d", cur_rk_valid, cur_rk_idx, exp_idx);
      end
      n_checks++; if (cur_rk_out !== exp128[exp_idx]) begin n_errors++;
        $display("FAIL bp_rk: got %h expected %h", cur_rk_out, exp128[exp_idx]); end
      n_checks++; if (cur_rk_last !== (exp_idx == 0)) begin n_errors++;
        $display("FAIL bp_last: got %b expected %b", cur_rk_last, exp_idx == 0); end
      if (stalled) begin
        n_checks++; if (cur_rk_out !== held) begin n_errors++;
          $display("FAIL bp_stable: got %h expected %h", cur_rk_out, held); end
      end
      go = (guard == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      rk_ready = go;
      if (go) begin
        beats++; exp_idx--; stalled = 1'b0;
      end else begin
        stalled = 1'b1; held = cur_rk_out;
      end
      @(posedge clk); #1;
    end
    rk_ready = 1'b1;
    n_checks++; if (beats != 11) begin n_errors++;
      $display("FAIL bp_beats: got %0d expected 11", beats); end
    n_checks++; if (cur_rk_valid !== 1'b0 || cur_key_ready !== 1'b1) begin n_errors++;
      $display("FAIL bp_end: got valid/ready %b%b expected 01", cur_rk_valid, cur_key_ready);
    end
  endtask

  task automatic test_busy_key();
    int cycles, nbusy;
    bit to;
    sel = 4; rk_ready = 1'b1;
    accept_key(Key128);
    repeat (3) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      key = KeyAlt; key_valid = 1'b1;
      n_checks++; if (cur_key_ready !== 1'b0) begin n_errors++;
        $display("FAIL busykey_ready[%0d]: got %b expected 0", c, cur_key_ready); end
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    wait_valid(cycles, nbusy, to);
    n_checks++; if (to) begin n_errors++;
      $display("FAIL busykey_timeout: got timeout expected rk_valid"); return; end
    for (int b = 0; b < 11; b++) begin
      n_checks++; if (cur_rk_out !== exp128[10 - b] || cur_key_ready !== 1'b0) begin
        n_errors++; $display("FAIL busykey_rk[%0d]: got %h/%b expected %h/0", b, cur_rk_out,
          cur_key_ready, exp128[10 - b]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int cycles, nbusy;
    bit to;
    sel = 4; rk_ready = 1'b1;
    accept_key(Key128);
    wait_valid(cycles, nbusy, to);
    repeat (11) begin @(posedge clk); #1; end
    n_checks++; if (cur_key_ready !== 1'b1) begin n_errors++;
      $display("FAIL b2b_ready: got %b expected 1", cur_key_ready); end
    accept_key(Key128);
    wait_valid(cycles, nbusy, to);
    n_checks++; if (to || cycles != 41) begin n_errors++;
      $display("FAIL b2b_latency: got %0d (timeout %b) expected 41", cycles, to); end
    n_checks++; if (cur_rk_idx !== 4'd10 || cur_rk_out !== exp128[10]) begin n_errors++;
      $display("FAIL b2b_first: got %0d/%h expected 10/%h", cur_rk_idx, cur_rk_out,
        exp128[10]); end
    repeat (11) begin @(posedge clk); #1; end
    n_checks++; if (cur_busy !== 1'b0) begin n_errors++;
      $display("FAIL b2b_end: got busy %b expected 0", cur_busy); end
  endtask

  task automatic test_mid_reset();
    int cycles, nbusy;
    bit to;
    sel = 4; rk_ready = 1'b1;
    accept_key(KeyAlt);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    n_checks++; if (cur_key_ready !== 1'b1 || cur_busy !== 1'b0 || cur_rk_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_expand: got ready/busy/valid %b%b%b expected 100",
        cur_key_ready, cur_busy, cur_rk_valid); end
    rk_ready = 1'b0;
    accept_key(KeyAlt);
    wait_valid(cycles, nbusy, to);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (cur_rk_valid !== 1'b1 || cur_rk_idx !== 4'd10) begin n_errors++;
      $display("FAIL rst_pre_output: got valid/idx %b/%0d expected 1/10", cur_rk_valid,
        cur_rk_idx); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    n_checks++; if (cur_key_ready !== 1'b1 || cur_busy !== 1'b0 || cur_rk_valid !== 1'b0 ||
                    cur_rk_last !== 1'b0) begin
      n_errors++; $display("FAIL rst_output: got ready/busy/valid/last %b%b%b%b expected 1000",
        cur_key_ready, cur_busy, cur_rk_valid, cur_rk_last); end
    n_checks++; if (cur_rk_out !== 128'h0 || cur_rk_idx !== 4'd0) begin n_errors++;
      $display("FAIL rst_output_bus: got %h/%0d expected 0/0", cur_rk_out, cur_rk_idx); end
    rk_ready = 1'b1;
    accept_key(Key128);
    wait_valid(cycles, nbusy, to);
    n_checks++; if (to || cycles != 41) begin n_errors++;
      $display("FAIL rst_fresh_latency: got %0d (timeout %b) expected 41", cycles, to); end
    for (int b = 0; b < 11; b++) begin
      n_checks++; if (cur_rk_out !== exp128[10 - b] || cur_rk_idx !== 4'(10 - b)) begin
        n_errors++; $display("FAIL rst_fresh_rk[%0d]: got %0d/%h expected %0d/%h", b,
          cur_rk_idx, cur_rk_out, 10 - b, exp128[10 - b]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; key = '0; key_valid = 1'b0; rk_ready = 1'b1; sel = 4;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    test_reset();
    test_aes128();
    test_aes_wide(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 12, 47,
                  128'he98ba06f448c773c8ecc720401002202,
                  128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                  128'h8e73b0f7da0e6452c810f32b809079e5);
    test_aes_wide(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  14, 53,
                  128'hfe4890d1e6188d0b046df344706c631e,
                  128'h1f352c073b6108d72d9810a30914dff4,
                  128'h603deb1015ca71be2b73aef0857d7781);
    test_backpressure();
    test_busy_key();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Sequential AES key-schedule engine for the decryption datapath. It accepts one cipher key, expands it one 32-bit word per clock into an internal round-key buffer, and then streams the round keys in reverse order (round NR down to round 0), one 128-bit key per handshake. It is the parametrised successor to the single-round combinational inverse key generator and supports AES-128, AES-192 and AES-256 through one parameter. It sits between the key-load interface and the inverse-cipher round pipeline.

## Interface

**Parameters**
- `NK`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error.
- `NR`, default NK+6: number of rounds (derived; do not override).
- `NW`, default 4*(NR+1): number of expanded words held in the buffer (derived).

**Ports**
- `clk`, input, 1: the only clock. Everything is sampled on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `key_in`, input, [0:255]: cipher key, left-justified. Only bits [0:32*NK-1] are used.
- `key_valid`, input, 1: `key_in` is valid.
- `key_ready`, output, 1: the block can accept a key (high only in IDLE).
- `rk_out`, output, [0:127]: current round key, laid out as {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- `rk_idx`, output, [0:3]: round number r of `rk_out`.
- `rk_valid`, output, 1: `rk_out` and `rk_idx` are valid.
- `rk_ready`, input, 1: the consumer accepts the current round key.
- `rk_last`, output, 1: the current key is round 0, the final beat.
- `busy`, output, 1: the block is in EXPAND or OUTPUT.

## Operation

**State machine:** IDLE → EXPAND → OUTPUT → IDLE.

- **IDLE**
  - `key_ready`=1.
  - On `key_valid && key_ready`: load w[0..NK-1] from `key_in`, set i=NK, set rcon=8'h01, and go to EXPAND.
- **EXPAND**
  - Each cycle computes one word: temp=w[i-1].
    - If i mod NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (shift left by 1; if the MSB was set, XOR with 8'h1b).
    - Else if NK==8 and i mod 8==4: temp = SubWord(temp).
  - Write w[i] = w[i-NK] ^ temp, then i = i+1.
  - After w[NW-1] is written: set r=NR and go to OUTPUT.
- **OUTPUT**
  - `rk_valid`=1, `rk_idx`=r, `rk_out`={w[4r]..w[4r+3]}, `rk_last`=(r==0).
  - On `rk_valid && rk_ready`: if r>0, r=r-1; if r==0, go to IDLE.
- **RotWord** is a one-byte left rotate. **SubWord** applies the forward FIPS-197 S-box to each of the four bytes.
- The index counter i is 6 bits and never wraps; the rcon sequence needs no reset between the 7/8/10 uses.

**Boundary conditions**
- `key_valid` while busy: ignored; `key_ready`=0 and the key is not captured.
- `rk_ready` low in OUTPUT: `rk_out`, `rk_idx` and `rk_last` hold stable. `rk_valid` never drops before the handshake.
- Last handshake: `key_ready` rises on the next cycle; a new key may be accepted that same cycle.
- `rst` asserted in any state: IDLE on the next edge. Any partially expanded buffer is abandoned, and its contents are don't-care.
- Outside OUTPUT: `rk_out`=0, `rk_idx`=0 and `rk_last`=0, so the bus is never undriven.

## Timing

**Reset values**
- `key_ready`=1
- `busy`=0
- `rk_valid`=0
- `rk_last`=0
- `rk_out`=0
- `rk_idx`=0

**Latency**
- Expansion takes E = NW-NK cycles: 40 for NK=4, 46 for NK=6, 52 for NK=8.
- `rk_valid` first rises E+1 cycles after the key-accepting edge.
- With `rk_ready` held high, all NR+1 keys stream out on consecutive cycles. Total occupancy is E+NR+2 cycles.

**Output timing:** `busy` goes high on the cycle after acceptance and falls together with `rk_valid` after the last handshake.

## Structure

- **Package `aes_pkg`:**
  - the state enum (IDLE/EXPAND/OUTPUT)
  - the `xtime` function
  - the constant `AES_RCON_POLY`=8'h1b
  - a legal-NK check function
  - the forward S-box table as a function
- **Sub-module `aes_sub_word`:** combinational, [0:31] in and [0:31] out, four forward S-boxes. Exactly one instance, shared by both SubWord cases.
- **Buffer:** NW×32 register array, written at index i, read by 4-word slice at 4r.

## Test plan

- **AES-128:** NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → after 41 cycles, first beat rk_idx=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6. The last beat has rk_idx=0, rk_out equal to the key, and rk_last=1.
- **AES-192:** NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → first beat rk_idx=12, rk_out=e98ba06f448c773c8ecc720401002202, 47 cycles after accept.
- **AES-256:** NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → first beat rk_idx=14, rk_out=fe4890d1e6188d0b046df344706c631e, 53 cycles after accept.
- **Backpressure:** in the AES-128 run, toggle `rk_ready` pseudo-randomly → 11 beats, rk_idx strictly 10..0, and outputs stable while stalled.
- **Busy-time key:** pulse key_valid with a different key during EXPAND → it is ignored; the output matches the first key and key_ready=0 throughout.
- **Mid-operation reset:** assert `rst` one cycle during EXPAND and again during OUTPUT → all outputs reach their reset values next edge; a fresh key then produces the correct full sequence.
